// File: rtl/sad_result_reader.sv
// sad_result_reader
// Walks the SAD result SRAM after the engine finishes, streams every entry out on a
// valid/ready port and keeps the smallest SAD with its index (best-match position).
// All outputs are registered; they are computed from the next state so that they
// line up with the state they describe.
module sad_result_reader #(
   parameter int A_WIDTH     = 7,
   parameter int D_WIDTH     = 32,
   parameter int NUM_ENTRIES = 128
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   output logic [A_WIDTH-1:0] Res_Addr,
   output logic               Res_RW,
   output logic               Res_En,
   input  logic [D_WIDTH-1:0] Res_Data,
   output logic [D_WIDTH-1:0] Out_Data,
   output logic [A_WIDTH-1:0] Out_Index,
   output logic               Out_Valid,
   input  logic               Out_Ready,
   output logic [D_WIDTH-1:0] Min_Sad,
   output logic [A_WIDTH-1:0] Min_Index,
   output logic               Busy,
   output logic               Done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_PRESENT,
      S_FIN
   } state_t;

   localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(NUM_ENTRIES - 1);
   localparam logic [A_WIDTH-1:0] IDX_ONE  = A_WIDTH'(1);

   state_t               state_q, state_d;
   logic [A_WIDTH-1:0]   idx_q, idx_d;
   logic [A_WIDTH-1:0]   res_addr_q, res_addr_d;
   logic                 res_en_q, res_en_d;
   logic [D_WIDTH-1:0]   out_data_q, out_data_d;
   logic [A_WIDTH-1:0]   out_index_q, out_index_d;
   logic                 out_valid_q, out_valid_d;
   logic [D_WIDTH-1:0]   min_sad_q, min_sad_d;
   logic [A_WIDTH-1:0]   min_index_q, min_index_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   // Next-state, datapath and registered-output decode for the read pass.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      idx_d       = idx_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      min_sad_d   = min_sad_q;
      min_index_d = min_index_q;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               idx_d       = '0;
               min_sad_d   = '1;
               min_index_d = '0;
               state_d     = S_READ;
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // SRAM data for idx is on Res_Data this cycle; capture it and update the minimum.
            out_data_d  = Res_Data;
            out_index_d = idx_q;
            // Strict compare so that ties keep the earlier (lower) index.
            if (Res_Data < min_sad_q) begin
               min_sad_d   = Res_Data;
               min_index_d = idx_q;
            end
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (Out_Ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = S_READ;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs follow the state being entered so they are valid in that state's cycle.
      res_en_d    = (state_d == S_READ);
      res_addr_d  = res_en_d ? idx_d : '0;
      out_valid_d = (state_d == S_PRESENT);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_FIN);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!Rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         res_addr_q  <= '0;
         res_en_q    <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_valid_q <= 1'b0;
         min_sad_q   <= '0;
         min_index_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         res_addr_q  <= res_addr_d;
         res_en_q    <= res_en_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_valid_q <= out_valid_d;
         min_sad_q   <= min_sad_d;
         min_index_q <= min_index_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // The reader never writes the result SRAM.
   assign Res_RW    = 1'b0;
   assign Res_Addr  = res_addr_q;
   assign Res_En    = res_en_q;
   assign Out_Data  = out_data_q;
   assign Out_Index = out_index_q;
   assign Out_Valid = out_valid_q;
   assign Min_Sad   = min_sad_q;
   assign Min_Index = min_index_q;
   assign Busy      = busy_q;
   assign Done      = done_q;

endmodule

// File: tb/tb_sad_result_reader.sv
// tb_sad_result_reader
// Directed bench: SRAM model, cycle-timestamp reference model with a per-cycle
// compare process, plus hand-computed literal expectations for each scenario.
module tb_sad_result_reader;

   localparam int AW = 7;
   localparam int DW = 32;
   localparam int NE = 128;

   logic          Clk;
   logic          Rst;
   logic          Start;
   logic [AW-1:0] Res_Addr;
   logic          Res_RW;
   logic          Res_En;
   logic [DW-1:0] Res_Data;
   logic [DW-1:0] Out_Data;
   logic [AW-1:0] Out_Index;
   logic          Out_Valid;
   logic          Out_Ready;
   logic [DW-1:0] Min_Sad;
   logic [AW-1:0] Min_Index;
   logic          Busy;
   logic          Done;

   int checks   = 0;
   int failures = 0;

   sad_result_reader #(.A_WIDTH(AW), .D_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .Res_Addr  (Res_Addr),
      .Res_RW    (Res_RW),
      .Res_En    (Res_En),
      .Res_Data  (Res_Data),
      .Out_Data  (Out_Data),
      .Out_Index (Out_Index),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Min_Sad   (Min_Sad),
      .Min_Index (Min_Index),
      .Busy      (Busy),
      .Done      (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Result SRAM: one-cycle read latency.
   logic [DW-1:0] mem [NE];
   logic [DW-1:0] sram_q;
   always @(posedge Clk) begin
      if (Res_En && !Res_RW) sram_q <= mem[Res_Addr];
   end
   assign Res_Data = sram_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the pass as timestamps (cycle of each entry's read)
   // rather than as a state machine. cyc numbers the cycle following each edge.
   int            cyc = 0;
   bit            m_known = 0;
   bit            m_active = 0;
   bit            m_fin = 0;
   int            m_cur = 0;
   int            m_read_at = 0;
   logic [DW-1:0] m_out_data = '0;
   int            m_out_idx = 0;
   logic [DW-1:0] m_min_sad = '0;
   int            m_min_idx = 0;

   function automatic bit m_valid(input int c);
      return m_active && !m_fin && (c >= m_read_at + 2);
   endfunction

   always @(posedge Clk) begin
      int c;
      c = cyc;
      if (!Rst) begin
         m_known    = 1;
         m_active   = 0;
         m_fin      = 0;
         m_out_data = '0;
         m_out_idx  = 0;
         m_min_sad  = '0;
         m_min_idx  = 0;
      end else if (!m_active) begin
         if (Start) begin
            m_active  = 1;
            m_fin     = 0;
            m_cur     = 0;
            m_read_at = c + 1;
            m_min_sad = '1;
            m_min_idx = 0;
         end
      end else if (m_fin) begin
         m_active = 0;
         m_fin    = 0;
      end else if (c == m_read_at + 1) begin
         m_out_data = mem[m_cur];
         m_out_idx  = m_cur;
         if (mem[m_cur] < m_min_sad) begin
            m_min_sad = mem[m_cur];
            m_min_idx = m_cur;
         end
      end else if (m_valid(c) && Out_Ready) begin
         if (m_cur == NE - 1) m_fin = 1;
         else begin
            m_cur     = m_cur + 1;
            m_read_at = c + 1;
         end
      end
      cyc = cyc + 1;
   end

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge Clk) begin
      bit exp_en;
      if (m_known) begin
         exp_en = m_active && !m_fin && (cyc == m_read_at);
         check("m_res_en",    Res_En,    exp_en);
         check("m_res_addr",  Res_Addr,  exp_en ? m_cur : 0);
         check("m_res_rw",    Res_RW,    0);
         check("m_out_valid", Out_Valid, m_valid(cyc));
         check("m_out_data",  Out_Data,  m_out_data);
         check("m_out_index", Out_Index, m_out_idx);
         check("m_min_sad",   Min_Sad,   m_min_sad);
         check("m_min_index", Min_Index, m_min_idx);
         check("m_busy",      Busy,      m_active);
         check("m_done",      Done,      m_active && m_fin);
      end
   end

   // Start pulse: one idle cycle first, then Start for one edge. Returns in the cycle after that edge.
   task automatic start_pass();
      @(posedge Clk); #1;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit found;
      found = 0;
      for (int k = 0; k < 1000 && !found; k++) begin
         @(negedge Clk);
         found = Done;
      end
      check(name, found, 1);
   endtask

   task automatic wait_valid(input int idx, input int bound);
      bit found;
      found = 0;
      for (int k = 0; k < bound && !found; k++) begin
         @(negedge Clk);
         found = Out_Valid && (Out_Index == AW'(idx));
      end
      check("valid_index_seen", found, 1);
   endtask

   initial begin
      int k;
      bit found;

      Rst       = 1'b0;
      Start     = 1'b1;
      Out_Ready = 1'b1;
      for (int i = 0; i < NE; i++) mem[i] = 32'(1000 - i);

      // 1: reset held with Start high keeps everything quiet.
      repeat (5) begin
         @(negedge Clk);
         check("rst_busy",  Busy,      0);
         check("rst_valid", Out_Valid, 0);
         check("rst_en",    Res_En,    0);
         check("rst_done",  Done,      0);
         check("rst_min",   Min_Sad,   0);
      end
      @(posedge Clk); #1;
      Rst   = 1'b1;
      Start = 1'b0;

      // 2: descending data, Ready high, latency and pass length.
      start_pass();
      @(negedge Clk);
      check("t2_en_at_start_plus1", Res_En, 1);
      check("t2_addr0", Res_Addr, 0);
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      check("t2_valid_at_start_plus3", Out_Valid, 1);
      check("t2_first_data", Out_Data, 1000);
      check("t2_first_index", Out_Index, 0);
      k = 3;
      while (!Done && k < 500) begin
         @(negedge Clk);
         k++;
      end
      check("t2_done_cycle", k, 385);
      check("t2_min_sad", Min_Sad, 873);
      check("t2_min_index", Min_Index, 127);

      // 3: tie between entries 5 and 40 keeps the lower index.
      for (int i = 0; i < NE; i++) mem[i] = 32'd100;
      mem[5]  = 32'd3;
      mem[40] = 32'd3;
      start_pass();
      wait_done("t3_done");
      check("t3_min_sad", Min_Sad, 3);
      check("t3_min_index", Min_Index, 5);

      // 4: stall at index 2 with Ready low for 10 cycles.
      for (int i = 0; i < NE; i++) mem[i] = 32'(i * 7 + 11);
      Out_Ready = 1'b0;
      start_pass();
      for (int e = 0; e <= 2; e++) begin
         wait_valid(e, 20);
         if (e < 2) begin
            Out_Ready = 1'b1;
            @(posedge Clk); #1;
            Out_Ready = 1'b0;
         end
      end
      repeat (10) begin
         @(negedge Clk);
         check("t4_stall_data",  Out_Data,  25);
         check("t4_stall_index", Out_Index, 2);
         check("t4_stall_valid", Out_Valid, 1);
         check("t4_stall_no_en", Res_En,    0);
      end
      Out_Ready = 1'b1;
      @(posedge Clk); #1;
      found = 0;
      for (int j = 0; j < 10 && !found; j++) begin
         @(negedge Clk);
         found = Res_En;
      end
      check("t4_next_read_seen", found, 1);
      check("t4_next_addr", Res_Addr, 3);
      wait_done("t4_done");
      check("t4_min_sad", Min_Sad, 11);
      check("t4_min_index", Min_Index, 0);

      // 5: Start mid-pass ignored; reset mid-pass aborts without Done; restart from 0.
      start_pass();
      wait_valid(50, 400);
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      wait_valid(60, 400);
      Rst = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(negedge Clk);
      check("t5_busy",     Busy,      0);
      check("t5_valid",    Out_Valid, 0);
      check("t5_en",       Res_En,    0);
      check("t5_data",     Out_Data,  0);
      check("t5_min_sad",  Min_Sad,   0);
      found = 0;
      repeat (5) begin
         @(negedge Clk);
         if (Done) found = 1;
      end
      check("t5_no_done", found, 0);
      start_pass();
      @(negedge Clk);
      check("t5_restart_en", Res_En, 1);
      check("t5_restart_addr", Res_Addr, 0);
      wait_done("t5_done");
      check("t5_min_after_restart", Min_Sad, 11);

      // 6: all entries all-ones -> minimum stays all-ones at index 0.
      for (int i = 0; i < NE; i++) mem[i] = 32'hFFFF_FFFF;
      start_pass();
      wait_done("t6_done");
      check("t6_min_sad", Min_Sad, 32'hFFFF_FFFF);
      check("t6_min_index", Min_Index, 0);

      repeat (3) @(posedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
